// File: rtl/conv_enc_213_framer_pkg.sv
// Shared constants and FSM encoding for the (2,1,3) framer / encoder.
//   N_OUT    : codeword width (n)
//   K_LEN    : constraint length (K); TAIL_LEN = K-1 zero tail bits
//   G0_DEF/G1_DEF : default generator polynomials (bit2 = current input)
//   state_t  : framer FSM states
package conv_enc_213_framer_pkg;
  localparam int N_OUT = 2;
  localparam int K_LEN = 3;
  localparam int TAIL_LEN = K_LEN - 1;
  localparam logic [K_LEN-1:0] G0_DEF = 3'b111;
  localparam logic [K_LEN-1:0] G1_DEF = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_TAIL = 2'd2,
    ST_GAP  = 2'd3
  } state_t;
endpackage

// File: rtl/conv_core_213.sv
// (2,1,3) convolutional encoder core: 2-bit shift register plus parity logic.
//   clock, reset : clock / async active-low reset
//   clr          : encode this bit as if sr were 00 (sequence start)
//   en           : advance sr with bit_in
//   bit_in       : info bit to encode
//   code_out     : combinational codeword {c0,c1} for bit_in
module conv_core_213
  import conv_enc_213_framer_pkg::*;
#(
  parameter logic [K_LEN-1:0] G0 = G0_DEF,
  parameter logic [K_LEN-1:0] G1 = G1_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [N_OUT-1:0] code_out
);
  logic [K_LEN-2:0] sr;
  logic [K_LEN-2:0] sr_eff;
  logic [K_LEN-1:0] s;

  assign sr_eff   = clr ? '0 : sr;
  assign s        = {bit_in, sr_eff};
  assign code_out = {^(s & G0), ^(s & G1)};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)  sr <= '0;
    else if (en) sr <= {bit_in, sr_eff[K_LEN-2]};
  end
endmodule

// File: rtl/conv_enc_213_framer.sv
// Sequence framer feeding a Viterbi decoder: takes SEQ_LEN info bits over a
// valid/ready handshake, encodes one codeword per clock, appends K-1 zero
// tail bits, then idles GAP_CYC cycles.
//   clock, reset     : clock / async active-low reset
//   din, din_valid   : info bit stream
//   din_ready        : high in IDLE and DATA
//   Rx_out, rx_valid : registered codeword {c0,c1} and its qualifier
//   seq_ready        : pulse with the first codeword of a sequence
//   underrun         : pulse with a codeword whose bit was zero-filled
//   busy             : sequence in progress (accept+1 .. end of gap)
// Optional macro CONV_ENC_ERR_INJECT_EN adds err_mask/err_pos: the codeword
// at index err_pos (tail included) is XORed with err_mask; both are captured
// at sequence start.
module conv_enc_213_framer
  import conv_enc_213_framer_pkg::*;
#(
  parameter int               SEQ_LEN = 16,
  parameter int               GAP_CYC = 2,
  parameter logic [K_LEN-1:0] G0      = G0_DEF,
  parameter logic [K_LEN-1:0] G1      = G1_DEF,
  parameter int               CW      = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
`ifdef CONV_ENC_ERR_INJECT_EN
  input  logic [N_OUT-1:0] err_mask,
  input  logic [CW-1:0]    err_pos,
`endif
  output logic             din_ready,
  output logic [N_OUT-1:0] Rx_out,
  output logic             rx_valid,
  output logic             seq_ready,
  output logic             underrun,
  output logic             busy
);
  state_t           state, state_nxt;
  logic [CW-1:0]    bit_cnt, gap_cnt;
  logic             tail_cnt;
  logic             accept, en, clr, bit_in, ur;
  logic             data_last, tail_last, gap_last;
  logic [N_OUT-1:0] code, inj;

  assign data_last = (bit_cnt == CW'(SEQ_LEN - 1));
  assign tail_last = (tail_cnt == 1'(TAIL_LEN - 1));
  assign gap_last  = (gap_cnt == CW'(GAP_CYC - 1));

  // Gated with reset so every output reads 0 while reset is held.
  assign din_ready = reset && ((state == ST_IDLE) || (state == ST_DATA));
  assign busy      = (state != ST_IDLE);

  conv_core_213 #(.G0(G0), .G1(G1)) u_core (
    .clock    (clock),
    .reset    (reset),
    .clr      (clr),
    .en       (en),
    .bit_in   (bit_in),
    .code_out (code)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    en        = 1'b0;
    clr       = 1'b0;
    bit_in    = 1'b0;
    ur        = 1'b0;
    unique case (state)
      ST_IDLE: if (din_valid) begin
        accept    = 1'b1;
        en        = 1'b1;
        clr       = 1'b1;
        bit_in    = din;
        state_nxt = (SEQ_LEN == 1) ? ST_TAIL : ST_DATA;
      end
      ST_DATA: begin
        // Missing data is zero-filled so the decoder sees no bubbles.
        en     = 1'b1;
        bit_in = din_valid & din;
        ur     = ~din_valid;
        if (data_last) state_nxt = ST_TAIL;
      end
      ST_TAIL: begin
        en = 1'b1;
        if (tail_last) state_nxt = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP: if (gap_last) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef CONV_ENC_ERR_INJECT_EN
  logic [N_OUT-1:0] mask_q, mask_eff;
  logic [CW-1:0]    pos_q, pos_eff;
  logic [CW:0]      cw_idx;

  // At the start cycle the live inputs apply; afterwards the captured copy.
  assign mask_eff = accept ? err_mask : mask_q;
  assign pos_eff  = accept ? err_pos  : pos_q;

  always_comb begin
    cw_idx = '0;
    if (state == ST_DATA)      cw_idx = {1'b0, bit_cnt};
    else if (state == ST_TAIL) cw_idx = (CW+1)'(SEQ_LEN) + {{CW{1'b0}}, tail_cnt};
  end

  assign inj = (cw_idx == {1'b0, pos_eff}) ? mask_eff : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mask_q <= '0;
      pos_q  <= '0;
    end else if (accept) begin
      mask_q <= err_mask;
      pos_q  <= err_pos;
    end
  end
`else
  assign inj = '0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      Rx_out    <= '0;
      rx_valid  <= 1'b0;
      seq_ready <= 1'b0;
      underrun  <= 1'b0;
      bit_cnt   <= '0;
      tail_cnt  <= 1'b0;
      gap_cnt   <= '0;
    end else begin
      rx_valid  <= en;
      seq_ready <= accept;
      underrun  <= ur;
      if (en) Rx_out <= code ^ inj;
      if (accept)                bit_cnt <= CW'(1);
      else if (state == ST_DATA) bit_cnt <= bit_cnt + CW'(1);
      if (state == ST_TAIL) tail_cnt <= ~tail_cnt;
      if (state == ST_GAP)  gap_cnt  <= gap_last ? '0 : gap_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_conv_enc_213_framer.sv
// Bench for conv_enc_213_framer: two instances (SEQ_LEN=4/GAP=2 and
// SEQ_LEN=1/GAP=0) driven with directed then random streams. The reference
// model keeps each sequence's bit list and forms codewords by convolving
// the bit history with the generators; expected codewords are queued with
// their due cycle and a negedge monitor pops and compares.
module tb_conv_enc_213_framer;
  localparam int CW = 5;
  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;
  localparam int SL0 = 4, GP0 = 2, SL1 = 1, GP1 = 0;

  typedef struct {
    int         cyc;
    logic [1:0] cw;
    logic       sr;
    logic       ur;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       din [2];
  logic       din_valid [2];
  logic       din_ready [2];
  logic [1:0] rx_out [2];
  logic       rx_valid [2];
  logic       seq_ready [2];
  logic       underrun [2];
  logic       busy [2];
`ifdef CONV_ENC_ERR_INJECT_EN
  logic [1:0]    err_mask [2];
  logic [CW-1:0] err_pos [2];
`endif

  exp_t q0[$], q1[$];
  int   k [2];
  int   blocked [2];
  logic bits [2][32];
  logic [1:0] mask_s [2];
  int   pos_s [2];
  logic [1:0] last_exp [2];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  conv_enc_213_framer #(.SEQ_LEN(SL0), .GAP_CYC(GP0), .G0(G0), .G1(G1), .CW(CW)) dut_a (
    .clock(clock), .reset(reset), .din(din[0]), .din_valid(din_valid[0]),
`ifdef CONV_ENC_ERR_INJECT_EN
    .err_mask(err_mask[0]), .err_pos(err_pos[0]),
`endif
    .din_ready(din_ready[0]), .Rx_out(rx_out[0]), .rx_valid(rx_valid[0]),
    .seq_ready(seq_ready[0]), .underrun(underrun[0]), .busy(busy[0]));

  conv_enc_213_framer #(.SEQ_LEN(SL1), .GAP_CYC(GP1), .G0(G0), .G1(G1), .CW(CW)) dut_b (
    .clock(clock), .reset(reset), .din(din[1]), .din_valid(din_valid[1]),
`ifdef CONV_ENC_ERR_INJECT_EN
    .err_mask(err_mask[1]), .err_pos(err_pos[1]),
`endif
    .din_ready(din_ready[1]), .Rx_out(rx_out[1]), .rx_valid(rx_valid[1]),
    .seq_ready(seq_ready[1]), .underrun(underrun[1]), .busy(busy[1]));

  function automatic int sl(int d); return (d == 0) ? SL0 : SL1; endfunction
  function automatic int gp(int d); return (d == 0) ? GP0 : GP1; endfunction

  task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d cyc=%0d actual=%0h expected=%0h", name, d, cyc, act, exp);
    end
  endtask

  // Codeword i = generator taps applied to bits i, i-1, i-2 of the sequence.
  function automatic logic [1:0] model_cw(int d, int i);
    logic b0, b1, b2;
    logic [1:0] r;
    b0 = bits[d][i];
    b1 = 1'b0;
    b2 = 1'b0;
    if (i >= 1) b1 = bits[d][i-1];
    if (i >= 2) b2 = bits[d][i-2];
    r[1] = (G0[2] & b0) ^ (G0[1] & b1) ^ (G0[0] & b2);
    r[0] = (G1[2] & b0) ^ (G1[1] & b1) ^ (G1[0] & b2);
    if (i == pos_s[d]) r = r ^ mask_s[d];
    return r;
  endfunction

  task automatic push(int d, int i, int due, logic sr, logic ur);
    exp_t e;
    e.cyc = due; e.cw = model_cw(d, i); e.sr = sr; e.ur = ur;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic enc(int d, logic b, logic ur, logic first);
    bits[d][k[d]] = b;
    push(d, k[d], cyc + 1, first, ur);
    k[d]++;
    if (k[d] == sl(d)) begin
      bits[d][k[d]] = 1'b0;
      bits[d][k[d]+1] = 1'b0;
      push(d, k[d], cyc + 2, 1'b0, 1'b0);
      push(d, k[d] + 1, cyc + 3, 1'b0, 1'b0);
      k[d] = 0;
      blocked[d] = 2 + gp(d);
    end
  endtask

  task automatic step(int d, logic v, logic b);
    chk("din_ready", d, din_ready[d], blocked[d] == 0);
    chk("busy", d, busy[d], (k[d] > 0) || (blocked[d] > 0));
    din_valid[d] = v;
    din[d] = b;
`ifdef CONV_ENC_ERR_INJECT_EN
    err_mask[d] = 2'($urandom_range(0, 3));
    err_pos[d]  = CW'($urandom_range(0, sl(d) + 1));
`endif
    if (blocked[d] > 0) blocked[d]--;
    else if (k[d] == 0) begin
      if (v) begin
`ifdef CONV_ENC_ERR_INJECT_EN
        mask_s[d] = err_mask[d];
        pos_s[d]  = int'(err_pos[d]);
`endif
        enc(d, b, 1'b0, 1'b1);
      end
    end else enc(d, v & b, ~v, 1'b0);
  endtask

  task automatic cycle(logic v0, logic b0, logic v1, logic b1);
    @(posedge clock);
    #1;
    step(0, v0, b0);
    step(1, v1, b1);
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      k[d] = 0; blocked[d] = 0; mask_s[d] = 2'b00; pos_s[d] = -1;
      last_exp[d] = 2'b00; din_valid[d] = 1'b0; din[d] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic chk_zero(string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_rx_valid"}, d, rx_valid[d], 0);
      chk({tag, "_seq_ready"}, d, seq_ready[d], 0);
      chk({tag, "_underrun"}, d, underrun[d], 0);
      chk({tag, "_busy"}, d, busy[d], 0);
      chk({tag, "_din_ready"}, d, din_ready[d], 0);
      chk({tag, "_rx_out"}, d, rx_out[d], 0);
    end
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    chk_zero("rst_mid");
    model_clear();
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b1;
  endtask

  task automatic mon(int d);
    exp_t e;
    bit   have;
    if (d == 0) while (q0.size() > 0 && q0[0].cyc < cyc) begin
      chk("missed_cw", d, q0[0].cyc, cyc); void'(q0.pop_front());
    end else while (q1.size() > 0 && q1[0].cyc < cyc) begin
      chk("missed_cw", d, q1[0].cyc, cyc); void'(q1.pop_front());
    end
    have = (d == 0) ? (q0.size() > 0 && q0[0].cyc == cyc)
                    : (q1.size() > 0 && q1[0].cyc == cyc);
    chk("rx_valid", d, rx_valid[d], have);
    if (have) begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      chk("rx_out", d, rx_out[d], e.cw);
      chk("seq_ready", d, seq_ready[d], e.sr);
      chk("underrun", d, underrun[d], e.ur);
      last_exp[d] = e.cw;
    end else begin
      chk("rx_hold", d, rx_out[d], last_exp[d]);
      chk("seq_ready_idle", d, seq_ready[d], 0);
      chk("underrun_idle", d, underrun[d], 0);
    end
  endtask

  always @(negedge clock) if (reset) begin
    mon(0);
    mon(1);
  end

  initial begin
    model_clear();
`ifdef CONV_ENC_ERR_INJECT_EN
    for (int d = 0; d < 2; d++) begin err_mask[d] = 2'b00; err_pos[d] = '0; end
`endif
    #1;
    chk_zero("rst_init");
    #11;
    reset = 1'b1;

    // 1011 back-to-back on A; single-bit sequence on B
    cycle(1, 1, 1, 1); cycle(1, 0, 0, 0); cycle(1, 1, 0, 0); cycle(1, 1, 0, 0);
    repeat (6) cycle(0, 0, 0, 0);
    // underrun on the third bit
    cycle(1, 1, 0, 0); cycle(1, 0, 0, 0); cycle(0, 1, 0, 0); cycle(1, 1, 0, 0);
    repeat (6) cycle(0, 0, 0, 0);
    // continuous valid: two sequences of 1011, B fed every cycle
    for (int r = 0; r < 2; r++) begin
      cycle(1, 1, 1, 1); cycle(1, 0, 1, 0); cycle(1, 1, 1, 1); cycle(1, 1, 1, 1);
      repeat (4) cycle(1, 1, 1, 0);
    end
    repeat (6) cycle(0, 0, 0, 0);
    // reset in the middle of a sequence, then restart from sr=00
    cycle(1, 1, 1, 1); cycle(1, 1, 0, 0);
    do_reset();
    cycle(1, 1, 1, 1); cycle(1, 0, 0, 0); cycle(1, 1, 0, 0); cycle(1, 1, 0, 0);
    repeat (6) cycle(0, 0, 0, 0);

    // random traffic
    repeat (2000)
      cycle(($urandom_range(0, 9) != 0), 1'($urandom()),
            ($urandom_range(0, 3) != 0), 1'($urandom()));
    repeat (10) cycle(0, 0, 0, 0);
    @(negedge clock);
    #1;
    chk("drain_queue", 0, q0.size(), 0);
    chk("drain_queue", 1, q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
